// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: result-source and load-type encodings
// plus the datapath width constants.
package mips_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_LOAD = 2'd1,
    WB_SEL_LINK = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LH  = 3'd1,
    LD_LHU = 3'd2,
    LD_LB  = 3'd3,
    LD_LBU = 3'd4
  } ld_type_e;

endpackage

// File: rtl/load_align.sv
// Big-endian sub-word extraction and extension of a loaded word, with
// detection of accesses that are not naturally aligned.
module load_align
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword, then extend according to the load type.
  always_comb begin
    case (addr)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      2'd3:    byte_sel = word[7:0];
      default: byte_sel = 8'd0;
    endcase
    half_sel = addr[1] ? word[15:0] : word[31:16];

    case (load_type)
      LD_LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LD_LHU: begin
        data       = {16'd0, half_sel};
        misaligned = addr[0];
      end
      LD_LB: begin
        data       = {{24{byte_sel[7]}}, byte_sel};
        misaligned = 1'b0;
      end
      LD_LBU: begin
        data       = {24'd0, byte_sel};
        misaligned = 1'b0;
      end
      default: begin
        data       = word;
        misaligned = (addr != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS32 writeback stage: MEM/WB pipeline register, result select and
// retired-instruction counter. All outputs come straight from flops.
module wb_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [1:0]        mem_wb_sel,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [XLEN-1:0]   mem_load_data,
  input  logic [2:0]        mem_load_type,
  input  logic [XLEN-1:0]   mem_link_pc,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_write_data,
  output logic              wb_misaligned,
  output logic [XLEN-1:0]   retire_count
);

  logic [XLEN-1:0] load_data;
  logic            load_misaligned;
  logic [XLEN-1:0] next_data;
  logic            next_misaligned;
  logic            next_reg_write;

  load_align u_align (
    .word       (mem_load_data),
    .addr       (mem_alu_result[1:0]),
    .load_type  (mem_load_type),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  // Result source select; misalignment only matters for a real load.
  always_comb begin
    case (mem_wb_sel)
      WB_SEL_LOAD: begin
        next_data       = load_data;
        next_misaligned = mem_valid & load_misaligned;
      end
      WB_SEL_LINK: begin
        next_data       = mem_link_pc;
        next_misaligned = 1'b0;
      end
      default: begin
        next_data       = mem_alu_result;
        next_misaligned = 1'b0;
      end
    endcase
    next_reg_write = mem_valid & mem_reg_write & (mem_rd != 5'd0) & ~next_misaligned;
  end

  // MEM/WB pipeline register: reset, then flush, then stall-hold, then capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= 5'd0;
      wb_write_data <= 32'd0;
      wb_misaligned <= 1'b0;
    end else if (flush) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= 5'd0;
      wb_write_data <= 32'd0;
      wb_misaligned <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= mem_valid;
      wb_reg_write  <= next_reg_write;
      wb_rd         <= mem_rd;
      wb_write_data <= next_data;
      wb_misaligned <= next_misaligned;
    end else begin
      wb_valid      <= wb_valid;
      wb_reg_write  <= wb_reg_write;
      wb_rd         <= wb_rd;
      wb_write_data <= wb_write_data;
      wb_misaligned <= wb_misaligned;
    end
  end

  // The occupant leaves WB whenever the register moves; a flush forces a move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_count <= 32'd0;
    end else if (wb_valid && (flush || !stall)) begin
      retire_count <= retire_count + 32'd1;
    end else begin
      retire_count <= retire_count;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a reference model pushes expected WB state
// to a scoreboard each cycle, popped and compared after the clock edge.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [2:0]  mem_load_type;
  logic [31:0] mem_link_pc;
  logic        stall;
  logic        flush;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_write_data;
  logic        wb_misaligned;
  logic [31:0] retire_count;

  typedef struct packed {
    logic        valid;
    logic        regw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic [31:0] cnt;
  } wb_exp_t;

  wb_exp_t sb[$];
  wb_exp_t model;
  int checks;
  int failures;

  wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_load_type  (mem_load_type),
    .mem_link_pc    (mem_link_pc),
    .stall          (stall),
    .flush          (flush),
    .wb_valid       (wb_valid),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_write_data  (wb_write_data),
    .wb_misaligned  (wb_misaligned),
    .retire_count   (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_align(input logic [31:0] w, input logic [1:0] a,
                                    input logic [2:0] t,
                                    output logic [31:0] d, output logic m);
    int sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = 24 - 8 * int'(a);
    b  = 8'(w >> sh);
    h  = a[1] ? w[15:0] : w[31:16];
    m  = 1'b0;
    if (t == 3'd1) begin
      d = {{16{h[15]}}, h}; m = a[0];
    end else if (t == 3'd2) begin
      d = {16'd0, h}; m = a[0];
    end else if (t == 3'd3) begin
      d = {{24{b[7]}}, b};
    end else if (t == 3'd4) begin
      d = {24'd0, b};
    end else begin
      d = w; m = (a != 2'd0);
    end
  endfunction

  // Advance the model with the currently driven inputs, clock, then compare.
  task automatic tick();
    wb_exp_t n;
    wb_exp_t got;
    logic [31:0] ld;
    logic lm;
    n = model;
    if (!rst_n) begin
      n = '0;
    end else begin
      if (model.valid && (flush || !stall)) n.cnt = model.cnt + 32'd1;
      if (flush) begin
        n.valid = 1'b0; n.regw = 1'b0; n.rd = 5'd0; n.data = 32'd0; n.mis = 1'b0;
      end else if (!stall) begin
        ref_align(mem_load_data, mem_alu_result[1:0], mem_load_type, ld, lm);
        n.valid = mem_valid;
        n.rd    = mem_rd;
        n.mis   = 1'b0;
        if (mem_wb_sel == 2'd1) begin
          n.data = ld; n.mis = lm & mem_valid;
        end else if (mem_wb_sel == 2'd2) begin
          n.data = mem_link_pc;
        end else begin
          n.data = mem_alu_result;
        end
        n.regw = mem_valid && mem_reg_write && (mem_rd != 5'd0) && !n.mis;
      end
    end
    model = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, got.valid});
    chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, got.regw});
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, got.rd});
    chk("wb_write_data", wb_write_data, got.data);
    chk("wb_misaligned", {31'd0, wb_misaligned}, {31'd0, got.mis});
    chk("retire_count", retire_count, got.cnt);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [2:0] lt);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_wb_sel     = sel;
    mem_alu_result = alu;
    mem_load_type  = lt;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model = '0;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    mem_load_data = 32'h80FF_7F01;
    mem_link_pc   = 32'h0040_0008;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), $urandom, 3'($urandom));
      stall = 1'($urandom);
      flush = 1'($urandom);
      tick();
    end
    chk("reset_count", retire_count, 32'd0);
    chk("reset_valid", {31'd0, wb_valid}, 32'd0);
    rst_n = 1'b1;
    stall = 1'b0;
    flush = 1'b0;

    // ALU writeback
    drive(1'b1, 1'b1, 5'd5, 2'd0, 32'h1234_5678, 3'd0);
    tick();
    chk("alu_data", wb_write_data, 32'h1234_5678);
    chk("alu_regw", {31'd0, wb_reg_write}, 32'd1);
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 3'd0);
    tick();
    chk("alu_retired", retire_count, 32'd1);

    // Sub-word loads from 0x80FF7F01
    drive(1'b1, 1'b1, 5'd8, 2'd1, 32'h0000_0100, 3'd3);
    tick();
    chk("lb_00", wb_write_data, 32'hFFFF_FF80);
    drive(1'b1, 1'b1, 5'd9, 2'd1, 32'h0000_0101, 3'd4);
    tick();
    chk("lbu_01", wb_write_data, 32'h0000_00FF);
    drive(1'b1, 1'b1, 5'd10, 2'd1, 32'h0000_0102, 3'd1);
    tick();
    chk("lh_10", wb_write_data, 32'h0000_7F01);
    drive(1'b1, 1'b1, 5'd11, 2'd1, 32'h0000_0100, 3'd2);
    tick();
    chk("lhu_00", wb_write_data, 32'h0000_80FF);
    drive(1'b1, 1'b1, 5'd12, 2'd1, 32'h0000_0104, 3'd0);
    tick();
    drive(1'b1, 1'b1, 5'd13, 2'd1, 32'h0000_0103, 3'd3);
    tick();

    // Misaligned loads
    drive(1'b1, 1'b1, 5'd14, 2'd1, 32'h0000_1002, 3'd0);
    tick();
    chk("lw_mis_flag", {31'd0, wb_misaligned}, 32'd1);
    chk("lw_mis_regw", {31'd0, wb_reg_write}, 32'd0);
    drive(1'b1, 1'b1, 5'd15, 2'd1, 32'h0000_1001, 3'd2);
    tick();
    drive(1'b1, 1'b1, 5'd15, 2'd0, 32'h0000_1001, 3'd2);
    tick();

    // Link, reserved select, $zero
    drive(1'b1, 1'b1, 5'd31, 2'd2, 32'h0000_0000, 3'd0);
    tick();
    chk("link_data", wb_write_data, 32'h0040_0008);
    drive(1'b1, 1'b1, 5'd3, 2'd3, 32'h0BAD_F00D, 3'd0);
    tick();
    drive(1'b1, 1'b1, 5'd0, 2'd0, 32'h0000_DEAD, 3'd0);
    tick();
    chk("zero_regw", {31'd0, wb_reg_write}, 32'd0);

    // Stall for three cycles with changing inputs
    drive(1'b1, 1'b1, 5'd7, 2'd0, 32'h0000_CAFE, 3'd0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(i + 20), 2'd0, 32'h5555_0000 + 32'(i), 3'd0);
      tick();
    end
    chk("stall_held", wb_write_data, 32'h0000_CAFE);

    // Stall and flush together: bubble, occupant retires
    flush = 1'b1;
    tick();
    chk("flush_bubble", {31'd0, wb_valid}, 32'd0);
    stall = 1'b0;
    flush = 1'b0;

    // Retire-count wrap
    drive(1'b1, 1'b1, 5'd6, 2'd0, 32'h0000_0066, 3'd0);
    tick();
    force dut.retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count;
    model.cnt = 32'hFFFF_FFFF;
    tick();
    chk("wrap_zero", retire_count, 32'd0);

    // Reset mid-operation discards the occupant
    rst_n = 1'b0;
    tick();
    chk("midreset_count", retire_count, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 3'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the MIPS32 pipeline: the MEM/WB pipeline register plus result selection and load-data alignment. It captures the MEM-stage result each cycle and drives the register file's write port (`rd`, `write_data`, `reg_write`) from registered outputs. It supports stall, flush, sub-word load extraction, misalignment suppression and a retired-instruction counter.

## Interface

Parameters:
- none; data width fixed at 32, register index at 5.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `mem_valid` in 1: MEM stage holds a real instruction.
- `mem_reg_write` in 1: instruction writes a GPR.
- `mem_rd` in 5: destination register.
- `mem_wb_sel` in 2: result source.
- `mem_alu_result` in 32: ALU result; also the load byte address.
- `mem_load_data` in 32: aligned word read from data memory.
- `mem_load_type` in 3: load width and sign.
- `mem_link_pc` in 32: return address for JAL/JALR.
- `stall` in 1: hold the WB register.
- `flush` in 1: replace the captured instruction with a bubble.
- `wb_valid` out 1: the WB slot holds a real instruction.
- `wb_reg_write` out 1: to the register file `reg_write`.
- `wb_rd` out 5: to the register file `rd`.
- `wb_write_data` out 32: to the register file `write_data`.
- `wb_misaligned` out 1: the WB instruction was a misaligned load.
- `retire_count` out 32: count of retired valid instructions.

## Operation

- `mem_wb_sel` encoding:
  - 0 ALU: `mem_alu_result`.
  - 1 LOAD: aligned load data.
  - 2 LINK: `mem_link_pc`.
  - 3 reserved, treated as ALU.
- `mem_load_type` encoding:
  - LW=0: whole word.
  - LH=1: sign-extend the selected halfword.
  - LHU=2: zero-extend the selected halfword.
  - LB=3: sign-extend the selected byte.
  - LBU=4: zero-extend the selected byte.
  - 5–7 treated as LW.
- Byte order is big-endian:
  - Byte at `addr[1:0]`=0 is `[31:24]`, 3 is `[7:0]`.
  - Halfword at `addr[1]`=0 is `[31:16]`.
- Misalignment applies only when `mem_wb_sel`=LOAD:
  - LW with `addr[1:0]`≠0, or LH/LHU with `addr[0]`≠0, is misaligned.
  - A misaligned load captures `wb_misaligned`=1 and `wb_reg_write`=0.
- Captured `wb_reg_write` = `mem_valid` & `mem_reg_write` & (`mem_rd`≠0) & !misaligned.
- Register update each edge, in priority order:
  - `rst_n`=0 → all outputs 0.
  - else `flush` → bubble: `wb_valid`, `wb_reg_write` and `wb_misaligned` = 0; `wb_rd` and `wb_write_data` = 0.
  - else `stall` → hold all outputs.
  - else → capture the new values.
- `retire_count`:
  - Increments on each edge where `wb_valid`=1 and the WB register is not stalled (the instruction leaves WB).
  - A flush does not block retirement of the current WB occupant.
  - Misaligned loads count as retired.
  - Wraps 0xFFFFFFFF→0.

## Timing

- Latency is 1 cycle: MEM values present before edge N appear on `wb_*` after edge N.
- The register file writes on edge N+1.
- All outputs are registered; no combinational path from input to output.
- Reset mid-operation discards the WB occupant without counting it; `retire_count` = 0 the cycle after.
- With `stall` and `flush` both high, flush wins and the occupant retires if valid.
- With `mem_valid`=0, a bubble is captured; `wb_rd` and `wb_write_data` may carry the input values but `wb_reg_write`=0.
- While stalled, `wb_reg_write` stays asserted. Repeated writes of the same value to the same register are harmless and intended.

## Structure

- Shared package `mips_pkg` holds:
  - `WB_SEL_ALU`, `WB_SEL_LOAD`, `WB_SEL_LINK`.
  - `LD_LW`, `LD_LH`, `LD_LHU`, `LD_LB`, `LD_LBU`.
  - Width constants `XLEN`=32, `REG_AW`=5.
- One sub-module `load_align`: combinational. Inputs are word, `addr[1:0]` and load type; outputs are the extended data and the misaligned flag.
- The top level holds the select mux, the pipeline register and the retire counter.

## Test plan

- **Reset:** `rst_n`=0 for 2 cycles with random inputs → all outputs 0; `retire_count`=0.
- **ALU writeback:** `mem_valid`=1, `mem_reg_write`=1, rd=5, sel=ALU, result=0x1234_5678 → next cycle `wb_reg_write`=1, `wb_rd`=5, data=0x1234_5678; `retire_count`=1 after one further edge.
- **Loads** from word 0x80FF_7F01:
  - LB addr=..00 → 0xFFFF_FF80.
  - LBU addr=..01 → 0x0000_00FF.
  - LH addr=..10 → 0x0000_7F01.
  - LHU addr=..00 → 0x0000_80FF.
- **Misaligned:** LW addr=0x1002 → `wb_misaligned`=1, `wb_reg_write`=0.
- **$zero:** rd=0 with ALU result 0xDEAD → `wb_reg_write`=0.
- **Stall/flush:**
  - Stall for 3 cycles → outputs held, count unchanged.
  - Stall and flush together with a valid occupant → bubble next cycle, count +1.
- **Wrap:** force `retire_count` to 0xFFFF_FFFF (or run to it), retire one → 0.
